// File: rtl/div_unit_pkg.sv
// Shared CPU package for the divide unit.
// Holds the divider FSM state type, the iteration count and the width of
// the iteration counter. Imported by div_unit and div_step.
package div_unit_pkg;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // One restoring iteration per quotient bit.
  localparam int DIV_CYCLES = 32;

  // Iteration counter width.
  localparam int DIV_CNT_W  = 6;

endpackage : div_unit_pkg

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
// Ports:
//   rem_i     - current partial remainder (always < divisor_i)
//   dvd_bit_i - next dividend bit, shifted into the remainder LSB
//   divisor_i - divisor magnitude
//   rem_o     - next partial remainder
//   q_bit_o   - quotient bit produced by this iteration
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem_i < divisor_i, so the shifted value is < 2*divisor and fits in
  // WIDTH+1 bits; the MSB of the trial difference is therefore a clean
  // "went negative" indicator.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    trial   = shifted - {1'b0, divisor_i};
    rem_o   = shifted[WIDTH-1:0];
    q_bit_o = 1'b0;
    if (!trial[WIDTH]) begin
      rem_o   = trial[WIDTH-1:0];
      q_bit_o = 1'b1;
    end
  end

endmodule : div_step

// File: rtl/div_unit.sv
// div_unit: multi-cycle signed restoring divider (HI = remainder, LO = quotient).
// Ports:
//   clock   - single clock, rising edge
//   reset   - synchronous active-high reset
//   DivCtrl - start request, sampled only in IDLE
//   DivU    - unsigned select, sampled with DivCtrl (only when DIV_UNIT_DIVU_EN is defined)
//   A, B    - dividend / divisor, captured at start
//   Hi, Lo  - remainder / quotient, held until the next completed division
//   DivDone - one-cycle pulse when Hi/Lo update
//   DivZero - one-cycle pulse when a start sees B == 0
// Optional feature macro: DIV_UNIT_DIVU_EN (adds DivU and unsigned mode).
// Timing: start accepted at edge t, 32 RUN cycles, one FIX cycle, results
// and DivDone registered at edge t+33 (visible in the DONE cycle).
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             DivCtrl,
`ifdef DIV_UNIT_DIVU_EN
  input  logic             DivU,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivDone,
  output logic             DivZero
);

  div_state_e           state_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0]     rem_q;    // partial remainder
  logic [WIDTH-1:0]     quo_q;    // dividend bits shift out the top, quotient bits in at the bottom
  logic [WIDTH-1:0]     dvs_q;    // divisor magnitude
  logic                 neg_quo_q;
  logic                 neg_rem_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 done_q;
  logic                 zero_q;

  logic             signed_op;
  logic             a_sign;
  logic             b_sign;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] rem_d;
  logic             q_bit_d;

`ifdef DIV_UNIT_DIVU_EN
  assign signed_op = ~DivU;
`else
  assign signed_op = 1'b1;
`endif

  // In unsigned mode the signs are forced to zero, so FIX passes results
  // through unchanged but still costs its cycle.
  assign a_sign = signed_op & A[WIDTH-1];
  assign b_sign = signed_op & B[WIDTH-1];
  // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
  assign a_abs  = a_sign ? -A : A;
  assign b_abs  = b_sign ? -B : B;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (quo_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_d),
    .q_bit_o   (q_bit_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      zero_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (DivCtrl) begin
            if (B == '0) begin
              zero_q <= 1'b1;
            end else begin
              rem_q     <= '0;
              quo_q     <= a_abs;
              dvs_q     <= b_abs;
              neg_quo_q <= a_sign ^ b_sign;
              neg_rem_q <= a_sign;
              cnt_q     <= '0;
              state_q   <= RUN;
            end
          end
        end
        RUN: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[WIDTH-2:0], q_bit_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == DIV_CNT_W'(DIV_CYCLES - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= neg_rem_q ? -rem_q : rem_q;
          lo_q    <= neg_quo_q ? -quo_q : quo_q;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign DivDone = done_q;
  assign DivZero = zero_q;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Start accepted at edge t; DivDone is expected right after edge t+33
// (the cycle t+34), DivZero right after edge t (the cycle t+1).
module tb_div_unit;

  logic        clock;
  logic        reset;
  logic        DivCtrl;
  logic        DivU;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        DivDone;
  logic        DivZero;

  int checks;
  int errors;

  div_unit #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .DivCtrl (DivCtrl),
`ifdef DIV_UNIT_DIVU_EN
    .DivU    (DivU),
`endif
    .A       (A),
    .B       (B),
    .Hi      (Hi),
    .Lo      (Lo),
    .DivDone (DivDone),
    .DivZero (DivZero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start a division at the next edge t and check latency, result and pulse width.
  task automatic run_div(input string tag, input logic u, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi);
    int n;
    @(negedge clock);
    A = a; B = b; DivU = u; DivCtrl = 1'b1;
    @(posedge clock); #1;              // edge t
    DivCtrl = 1'b0;
    n = 0;
    while (n < 40 && DivDone !== 1'b1) begin
      @(posedge clock); #1;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'd33);
    chk({tag, " Lo"}, Lo, exp_lo);
    chk({tag, " Hi"}, Hi, exp_hi);
    chk({tag, " DivZero"}, {31'd0, DivZero}, 32'd0);
    @(posedge clock); #1;
    chk({tag, " DivDone pulse"}, {31'd0, DivDone}, 32'd0);
    chk({tag, " Lo held"}, Lo, exp_lo);
    $display("div %s: A=%h B=%h -> Lo=%h Hi=%h after %0d edges", tag, a, b, Lo, Hi, n);
  endtask

  initial begin
    int seen;
    checks = 0; errors = 0;
    reset = 1'b1; DivCtrl = 1'b0; DivU = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset Hi", Hi, 32'd0);
    chk("reset Lo", Lo, 32'd0);
    chk("reset DivDone", {31'd0, DivDone}, 32'd0);
    chk("reset DivZero", {31'd0, DivZero}, 32'd0);
    @(negedge clock); reset = 1'b0;

    run_div("100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);

    // Zero divisor: pulse at t+1, no DivDone, previous results kept.
    @(negedge clock);
    A = 32'd5; B = 32'd0; DivCtrl = 1'b1;
    @(posedge clock); #1;
    DivCtrl = 1'b0;
    chk("div0 DivZero", {31'd0, DivZero}, 32'd1);
    chk("div0 DivDone", {31'd0, DivDone}, 32'd0);
    @(posedge clock); #1;
    chk("div0 DivZero pulse", {31'd0, DivZero}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (DivDone === 1'b1) seen++;
    end
    chk("div0 no DivDone", 32'(seen), 32'd0);
    chk("div0 Lo kept", Lo, 32'd14);
    chk("div0 Hi kept", Hi, 32'd2);
    $display("div0: A=5 B=0 -> Lo=%h Hi=%h", Lo, Hi);

    run_div("-7/2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("7/-2", 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run_div("-7/-2", 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
    run_div("min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);

    // Abort: start 1000/3, ignored re-start at t+5, reset at edge t+10.
    @(negedge clock);
    A = 32'd1000; B = 32'd3; DivCtrl = 1'b1;
    @(posedge clock); #1;              // edge t
    DivCtrl = 1'b0;
    seen = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 5) begin A = 32'd9; B = 32'd9; DivCtrl = 1'b1; end
      if (i == 6) DivCtrl = 1'b0;
      if (i == 10) reset = 1'b1;
      @(posedge clock); #1;            // edge t+i
      if (DivDone === 1'b1) seen++;
    end
    reset = 1'b0;
    chk("abort Hi", Hi, 32'd0);
    chk("abort Lo", Lo, 32'd0);
    repeat (40) begin
      @(posedge clock); #1;
      if (DivDone === 1'b1) seen++;
    end
    chk("abort no DivDone", 32'(seen), 32'd0);
    $display("abort: Lo=%h Hi=%h DivDone seen=%0d", Lo, Hi, seen);

    run_div("20/4", 1'b0, 32'd20, 32'd4, 32'd5, 32'd0);

`ifdef DIV_UNIT_DIVU_EN
    run_div("divu", 1'b1, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 32'd0);
    run_div("div", 1'b0, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_div_unit

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 32, giving the operand and result width; only 32 is verified.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset sampled on the rising edge of clock.
REQ-004 The block SHALL have port DivCtrl, input, 1, start request from the control unit, sampled only in IDLE.
REQ-005 The block SHALL have port A, input, WIDTH, dividend from register A, captured at start.
REQ-006 The block SHALL have port B, input, WIDTH, divisor from register B, captured at start.
REQ-007 The block SHALL have port Hi, output, WIDTH, remainder, feeding the HI select mux.
REQ-008 The block SHALL have port Lo, output, WIDTH, quotient, feeding the LO select mux.
REQ-009 The block SHALL have port DivDone, output, 1, one-cycle pulse when Hi and Lo are updated.
REQ-010 The block SHALL have port DivZero, output, 1, one-cycle pulse flagging a zero divisor.

Function
REQ-011 The block SHALL implement FSM states IDLE, RUN, FIX and DONE.
REQ-012 In IDLE with DivCtrl=1 and B!=0 at edge t, the block SHALL latch |A| and |B| plus both sign bits and enter RUN.
REQ-013 In IDLE with DivCtrl=1 and B==0 at edge t, the block SHALL pulse DivZero during cycle t+1, stay in IDLE and leave Hi and Lo unchanged.
REQ-014 RUN SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles, with the iteration count held in a 6-bit counter, then enter FIX.
REQ-015 FIX SHALL negate the quotient when the operand signs differ and negate the remainder when A is negative, then enter DONE.
REQ-016 DONE SHALL be the cycle t+34, in which Hi and Lo become valid and DivDone=1; the FSM SHALL return to IDLE on the next edge.
REQ-017 Hi and Lo SHALL hold their values until the next completed division or a reset.
REQ-018 The quotient SHALL truncate toward zero, and the remainder SHALL carry the sign of the dividend.
REQ-019 The case 0x80000000 / 0xFFFFFFFF SHALL produce the wrapped result Lo=0x80000000, Hi=0, with no flag raised.
REQ-020 The block SHALL ignore DivCtrl in RUN, FIX and DONE.
REQ-021 DivDone and DivZero SHALL never be asserted in the same cycle.

Reset
REQ-022 While reset=1, the block SHALL set the state to IDLE and Hi, Lo, DivDone, DivZero, the counter and all working registers to 0.
REQ-023 A reset asserted during RUN or FIX SHALL abort the operation without a DivDone pulse, and reset SHALL take priority over DivCtrl.

Configuration
REQ-024 When macro DIV_UNIT_DIVU_EN is defined, the block SHALL have an extra input DivU (1 bit, sampled with DivCtrl); DivU=1 SHALL select unsigned operation with no sign handling, and FIX SHALL still take one cycle so latency is unchanged.
REQ-025 When DIV_UNIT_DIVU_EN is undefined, port DivU SHALL be absent and all divisions SHALL be signed.

Structure
REQ-026 The state enum, DIV_CYCLES=32 and the counter width SHALL be placed in the shared CPU package.
REQ-027 One combinational sub-module, div_step, SHALL implement a single restoring iteration (partial remainder, divisor, quotient bit in; next values out), instantiated once.

Verification
REQ-028 A=100, B=7, DivCtrl pulse at t -> DivDone at t+34, Lo=14, Hi=2.
REQ-029 A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
REQ-030 Previous result Lo=14, Hi=2; then A=5, B=0 -> DivZero at t+1, no DivDone, Lo=14, Hi=2 retained.
REQ-031 A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0, DivZero=0.
REQ-032 Start 1000/3, DivCtrl re-pulsed at t+5 with A=9, B=9, reset at t+10 -> Hi=Lo=0 from t+11 with no DivDone; a new start 20/4 -> Lo=5, Hi=0 after 34 cycles.
REQ-033 With DIV_UNIT_DIVU_EN defined: DivU=1, A=0xFFFFFFFE, B=2 -> Lo=0x7FFFFFFF, Hi=0; DivU=0 with the same operands -> Lo=0xFFFFFFFF, Hi=0.
